// File: rtl/dm_pkg.sv
// Shared encodings for the subword data memory: access widths, controller
// states and the byte-enable decode used by the store merge.
package dm_pkg;

  localparam logic [1:0] W_WORD = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_BYTE = 2'b10;

  typedef enum logic {CLEAR, RUN} state_t;

  // Lanes touched by an access of the given width at byte offset lane.
  function automatic logic [3:0] byte_en(input logic [1:0] width, input logic [1:0] lane);
    case (width)
      W_WORD:  byte_en = 4'b1111;
      W_HALF:  byte_en = lane[1] ? 4'b1100 : 4'b0011;
      W_BYTE:  byte_en = 4'b0001 << lane;
      default: byte_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Combinational lane logic: merges right-justified store data into the
// addressed word and extracts/extends the selected lane for loads.
import dm_pkg::*;

module dm_lane_unit (
  input  logic [1:0]  width,
  input  logic        sign,
  input  logic [1:0]  lane,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [3:0]  be;
  logic [31:0] rep;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    be = byte_en(width, lane);
    // Replicate the narrow datum so every enabled lane sees the right bytes.
    case (width)
      W_BYTE:  rep = {4{wdata[7:0]}};
      W_HALF:  rep = {2{wdata[15:0]}};
      default: rep = wdata;
    endcase
    merged = old_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = rep[8*i +: 8];
    end
  end

  always_comb begin
    case (lane)
      2'd0:    sel_b = old_word[7:0];
      2'd1:    sel_b = old_word[15:8];
      2'd2:    sel_b = old_word[23:16];
      default: sel_b = old_word[31:24];
    endcase
    sel_h = lane[1] ? old_word[31:16] : old_word[15:0];
    case (width)
      W_BYTE:  load_data = {{24{sign & sel_b[7]}}, sel_b};
      W_HALF:  load_data = {{16{sign & sel_h[15]}}, sel_h};
      default: load_data = old_word;
    endcase
  end

endmodule

// File: rtl/dm_subword_ctrl.sv
// MEM-stage data memory with word/half/byte access, range/alignment checks and
// a one-word-per-cycle clear sweep after reset. Define DM_SUBWORD_TRACE_EN for store trace.
import dm_pkg::*;

module dm_subword_ctrl #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_width,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_pc,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata
);

  localparam int unsigned IW = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t            state;
  logic [IW-1:0]     clr_cnt;
  logic [31:0]       mem [DEPTH_WORDS];
  logic [ADDR_W-1:0] offset;
  logic [IW-1:0]     idx;
  logic              err;
  logic              accept;
  logic [31:0]       merged;
  logic [31:0]       load_data;

  assign req_ready = (state == RUN) && !reset;
  assign accept    = req_valid && req_ready;
  assign offset    = req_addr - BASE;
  assign idx       = offset[IW+1:2];

  always_comb begin
    err = 1'b0;
    if (req_width == 2'b11)                        err = 1'b1;
    if (req_width == W_HALF && offset[0])          err = 1'b1;
    if (req_width == W_WORD && (offset[1:0] != '0)) err = 1'b1;
    if (req_addr < BASE)                           err = 1'b1;
    if (offset[ADDR_W-1:IW+2] != '0)               err = 1'b1;
  end

  dm_lane_unit u_lane (
    .width     (req_width),
    .sign      (req_sign),
    .lane      (offset[1:0]),
    .old_word  (mem[idx]),
    .wdata     (req_wdata),
    .merged    (merged),
    .load_data (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == IW'(DEPTH_WORDS - 1)) state <= RUN;
    end
  end

  // Array carries no reset; the CLEAR sweep zeroes it word by word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR)
        mem[clr_cnt] <= '0;
      else if (accept && req_we && !err)
        mem[idx] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else if (accept && err) begin
      rsp_valid <= 1'b1;
      rsp_err   <= 1'b1;
      rsp_rdata <= '0;
    end else if (accept && !req_we) begin
      rsp_valid <= 1'b1;
      rsp_err   <= 1'b0;
      rsp_rdata <= load_data;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end
  end

`ifdef DM_SUBWORD_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && accept && req_we && !err)
      $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[ADDR_W-1:2], 2'b00}, merged);
  end
`else
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_dm_subword_ctrl.sv
// Directed bench for dm_subword_ctrl: clear sweep timing, subword loads/stores,
// error checks, back-to-back store/load and reset during the clear sweep.
module tb_dm_subword_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_width = 2'b00;
  logic        req_sign = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_pc = '0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic        we;
    logic [1:0]  w;
    logic        s;
    logic [31:0] a;
    logic [31:0] d;
    logic        ev;
    logic        ee;
    logic [31:0] er;
  } vec_t;

  always #5 clk = ~clk;

  dm_subword_ctrl #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h0), .ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_width (req_width),
    .req_sign  (req_sign),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_pc    (req_pc),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata)
  );

  // Called at a negedge; presents one request for one posedge and returns at the next negedge.
  task automatic drive(input logic we, input logic [1:0] w, input logic s,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_we    = we;
    req_width = w;
    req_sign  = s;
    req_addr  = a;
    req_wdata = d;
    req_pc    = req_pc + 32'd4;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  // Releases reset after one posedge and counts not-ready negedges (bounded).
  task automatic release_and_count(output int zeros);
    @(posedge clk);
    #1 reset = 1'b0;
    zeros = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (req_ready) break;
      zeros++;
    end
  endtask

  task automatic test_reset;
    int zeros;
    @(negedge clk);
    nvec++;
    if (req_ready !== 1'b0) begin
      nerr++;
      $display("FAIL reset_ready: got %b expected 0", req_ready);
    end
    release_and_count(zeros);
    nvec++;
    if (zeros !== 4096) begin
      nerr++;
      $display("FAIL clear_cycles: got %0d expected 4096", zeros);
    end
    nvec++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      nerr++;
      $display("FAIL reset_rsp: got v=%b e=%b d=%h expected 0 0 00000000", rsp_valid, rsp_err, rsp_rdata);
    end
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    nvec++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      nerr++;
      $display("FAIL first_lw: got v=%b e=%b d=%h expected 1 0 00000000", rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_subword;
    vec_t v[10];
    v[0] = '{1'b1, 2'b00, 1'b0, 32'h10, 32'h12345678, 1'b0, 1'b0, 32'h0};
    v[1] = '{1'b0, 2'b10, 1'b1, 32'h13, 32'h0, 1'b1, 1'b0, 32'h00000012};
    v[2] = '{1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 1'b1, 1'b0, 32'h00000078};
    v[3] = '{1'b1, 2'b10, 1'b0, 32'h11, 32'h80, 1'b0, 1'b0, 32'h0};
    v[4] = '{1'b0, 2'b10, 1'b1, 32'h11, 32'h0, 1'b1, 1'b0, 32'hFFFFFF80};
    v[5] = '{1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 1'b1, 1'b0, 32'h00000080};
    v[6] = '{1'b1, 2'b01, 1'b0, 32'h12, 32'hBEEF, 1'b0, 1'b0, 32'h0};
    v[7] = '{1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1, 1'b0, 32'hFFFFBEEF};
    v[8] = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1, 1'b0, 32'h0000BEEF};
    v[9] = '{1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hBEEF8078};
    for (int i = 0; i < 10; i++) begin
      drive(v[i].we, v[i].w, v[i].s, v[i].a, v[i].d);
      nvec++;
      if (rsp_valid !== v[i].ev || rsp_err !== v[i].ee ||
          (v[i].ev && rsp_rdata !== v[i].er)) begin
        nerr++;
        $display("FAIL subword[%0d]: got v=%b e=%b d=%h expected v=%b e=%b d=%h",
                 i, rsp_valid, rsp_err, rsp_rdata, v[i].ev, v[i].ee, v[i].er);
      end
    end
  endtask

  task automatic test_errors;
    vec_t v[8];
    v[0] = '{1'b0, 2'b00, 1'b0, 32'h06, 32'h0, 1'b1, 1'b1, 32'h0};
    v[1] = '{1'b1, 2'b01, 1'b0, 32'h11, 32'h1234, 1'b1, 1'b1, 32'h0};
    v[2] = '{1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hBEEF8078};
    v[3] = '{1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h0};
    v[4] = '{1'b0, 2'b00, 1'b0, 32'h4000, 32'h0, 1'b1, 1'b1, 32'h0};
    v[5] = '{1'b1, 2'b00, 1'b0, 32'h4000, 32'h55AA55AA, 1'b1, 1'b1, 32'h0};
    v[6] = '{1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0};
    v[7] = '{1'b0, 2'b10, 1'b0, 32'h3FFF, 32'h0, 1'b1, 1'b0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      drive(v[i].we, v[i].w, v[i].s, v[i].a, v[i].d);
      nvec++;
      if (rsp_valid !== v[i].ev || rsp_err !== v[i].ee || rsp_rdata !== v[i].er) begin
        nerr++;
        $display("FAIL errors[%0d]: got v=%b e=%b d=%h expected v=%b e=%b d=%h",
                 i, rsp_valid, rsp_err, rsp_rdata, v[i].ev, v[i].ee, v[i].er);
      end
    end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 2'b00, 1'b0, 32'h20, 32'hCAFEF00D);
    drive(1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
    nvec++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D) begin
      nerr++;
      $display("FAIL b2b_sw_lw: got v=%b d=%h expected 1 cafef00d", rsp_valid, rsp_rdata);
    end
    drive(1'b1, 2'b10, 1'b0, 32'h21, 32'h000000A5);
    drive(1'b0, 2'b10, 1'b0, 32'h21, 32'h0);
    nvec++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h000000A5) begin
      nerr++;
      $display("FAIL b2b_sb_lbu: got v=%b d=%h expected 1 000000a5", rsp_valid, rsp_rdata);
    end
    @(negedge clk);
    nvec++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h000000A5) begin
      nerr++;
      $display("FAIL idle_hold: got v=%b d=%h expected 0 000000a5", rsp_valid, rsp_rdata);
    end
    drive(1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
    nvec++;
    if (rsp_rdata !== 32'hCAFEA50D) begin
      nerr++;
      $display("FAIL b2b_word: got %h expected cafea50d", rsp_rdata);
    end
  endtask

  task automatic test_mid_clear_reset;
    int zeros;
    drive(1'b1, 2'b00, 1'b0, 32'h14, 32'hFFFFFFFF);
    drive(1'b0, 2'b00, 1'b0, 32'h14, 32'h0);
    nvec++;
    if (rsp_rdata !== 32'hFFFFFFFF) begin
      nerr++;
      $display("FAIL fill_word5: got %h expected ffffffff", rsp_rdata);
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    release_and_count(zeros);
    nvec++;
    if (zeros !== 4096) begin
      nerr++;
      $display("FAIL mid_clear_cycles: got %0d expected 4096", zeros);
    end
    drive(1'b0, 2'b00, 1'b0, 32'h14, 32'h0);
    nvec++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      nerr++;
      $display("FAIL word5_cleared: got v=%b e=%b d=%h expected 1 0 00000000", rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  initial begin
    test_reset;
    test_subword;
    test_errors;
    test_back_to_back;
    test_mid_clear_reset;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
